// File: rtl/result_transmitter.sv
// Streams an N x N result matrix out over a byte-wide UART: a header byte {0,N}
// followed by every element, row-major, most-significant byte first.
module result_transmitter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        matrix_size,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              busy,
    output logic              done,
    output logic [2:0]        dbg_state
);

    localparam int BYTES = DATA_W / 8;
    localparam logic [1:0] LAST_BYTE = 2'(BYTES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND_SIZE = 3'd1,
        FETCH     = 3'd2,
        LOAD      = 3'd3,
        SEND_BYTE = 3'd4,
        WAIT_TX   = 3'd5,
        DONE      = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          n_q, n_d;
    logic [7:0]          total_q, total_d;
    logic [7:0]          elem_q, elem_d;
    logic [1:0]          byte_q, byte_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                hdr_q, hdr_d;
    logic                guard_q, guard_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic                tx_start_d;
    logic [7:0]          tx_data_d;
    logic [7:0]          elem_next;

    assign elem_next = elem_q + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            n_q      <= '0;
            total_q  <= '0;
            elem_q   <= '0;
            byte_q   <= '0;
            shift_q  <= '0;
            hdr_q    <= 1'b0;
            guard_q  <= 1'b0;
            mem_addr <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            total_q  <= total_d;
            elem_q   <= elem_d;
            byte_q   <= byte_d;
            shift_q  <= shift_d;
            hdr_q    <= hdr_d;
            guard_q  <= guard_d;
            mem_addr <= mem_addr_d;
            tx_start <= tx_start_d;
            tx_data  <= tx_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        total_d    = total_q;
        elem_d     = elem_q;
        byte_d     = byte_q;
        shift_d    = shift_q;
        hdr_d      = hdr_q;
        guard_d    = guard_q;
        mem_addr_d = mem_addr;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data;
        case (state_q)
            IDLE: begin
                if (start) begin
                    n_d     = matrix_size;
                    total_d = 8'(matrix_size) * 8'(matrix_size);
                    elem_d  = '0;
                    byte_d  = '0;
                    hdr_d   = 1'b1;
                    state_d = SEND_SIZE;
                end
            end
            SEND_SIZE: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = {4'h0, n_q};
                    guard_d    = 1'b1;
                    state_d    = WAIT_TX;
                end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                shift_d = mem_rdata;
                byte_d  = '0;
                state_d = SEND_BYTE;
            end
            SEND_BYTE: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = shift_q[DATA_W-1 -: 8];
                    shift_d    = shift_q << 8;
                    guard_d    = 1'b1;
                    state_d    = WAIT_TX;
                end
            end
            WAIT_TX: begin
                // The UART raises tx_busy a cycle after tx_start, so the first cycle here is blind.
                if (guard_q) begin
                    guard_d = 1'b0;
                end else if (!tx_busy) begin
                    if (hdr_q) begin
                        hdr_d = 1'b0;
                        if (total_q == 8'd0) begin
                            state_d = DONE;
                        end else begin
                            mem_addr_d = ADDR_W'(elem_q);
                            state_d    = FETCH;
                        end
                    end else if (byte_q != LAST_BYTE) begin
                        byte_d  = byte_q + 2'd1;
                        state_d = SEND_BYTE;
                    end else begin
                        elem_d = elem_next;
                        if (elem_next < total_q) begin
                            mem_addr_d = ADDR_W'(elem_next);
                            state_d    = FETCH;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q != IDLE) && (state_q != DONE);
    assign done      = (state_q == DONE);
    assign dbg_state = state_q;

endmodule

// File: doc/result_transmitter.md
RESULT_TRANSMITTER -- requirements
Module: result_transmitter

Interface
REQ-001 SHALL have parameter DATA_W, default 16, result element width in bits, a multiple of 8 and at most 32.
REQ-002 SHALL have parameter ADDR_W, default 8, result buffer address width.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, one-cycle request to transmit the result matrix.
REQ-006 SHALL have port matrix_size, input, 4, matrix dimension N (0..15), sampled on an accepted start.
REQ-007 SHALL have port mem_addr, output, ADDR_W, result buffer read address, row-major.
REQ-008 SHALL have port mem_rdata, input, DATA_W, result buffer read data, valid exactly 1 cycle after mem_addr.
REQ-009 SHALL have port tx_busy, input, 1, UART transmitter busy flag.
REQ-010 SHALL have port tx_start, output, 1, one-cycle pulse launching the byte on tx_data.
REQ-011 SHALL have port tx_data, output, 8, byte to transmit; stable while tx_start is high.
REQ-012 SHALL have port busy, output, 1, high from accepted start until done.
REQ-013 SHALL have port done, output, 1, one-cycle pulse after the last byte completes.

Function
REQ-014 SHALL implement states IDLE, SEND_SIZE, FETCH, LOAD, SEND_BYTE, WAIT_TX, DONE.
REQ-015 SHALL accept start only in IDLE; start while busy is ignored.
REQ-016 On an accepted start, SHALL latch N, set total = N*N (8-bit), clear element index and byte index, and enter SEND_SIZE.
REQ-017 SEND_SIZE SHALL send byte {4'h0, N} as the header before any element.
REQ-018 A byte SHALL be launched only when tx_busy is 0: tx_start high for exactly one cycle, tx_data updated on the same edge.
REQ-019 After each tx_start, SHALL ignore tx_busy for exactly one cycle, then remain in WAIT_TX until tx_busy is 0.
REQ-020 FETCH SHALL drive mem_addr = element index for one cycle; LOAD SHALL capture mem_rdata into a DATA_W shift register on the next edge.
REQ-021 Each element SHALL be sent as DATA_W/8 bytes, most-significant byte first.
REQ-022 After the last byte of an element, SHALL increment the element index and go to FETCH if index < total, else DONE.
REQ-023 If N = 0, SHALL send only the header byte 0x00, then go to DONE with no memory reads.
REQ-024 DONE SHALL pulse done for one cycle, deassert busy, and return to IDLE in the next cycle.
REQ-025 A new start SHALL be accepted in the cycle after done, without an intervening idle cycle.
REQ-026 The total byte count per transfer SHALL be 1 + N*N*(DATA_W/8).
REQ-027 mem_addr SHALL hold its last value outside FETCH; tx_start SHALL be 0 outside launch cycles.
REQ-028 If tx_busy is already high when a byte is due, SHALL wait without asserting tx_start.

Reset
REQ-029 rst_n low SHALL immediately force IDLE and set tx_start=0, tx_data=0, mem_addr=0, busy=0, done=0, and clear the counters and shift register.
REQ-030 Reset asserted mid-transfer SHALL abort the transfer with no further tx_start; after release, the block SHALL wait for a new start.

Verification
REQ-031 The bench SHALL cover: N=2, buffer {0x0102,0x0304,0x0506,0x0708}, tx_busy model 10 cycles -> bytes 02,01,02,03,04,05,06,07,08, then one done pulse.
REQ-032 The bench SHALL cover: N=0 -> single byte 00, done, no mem_addr change.
REQ-033 The bench SHALL cover: tx_busy held high for 50 cycles at start -> no tx_start until tx_busy falls, then header 0x03 for N=3.
REQ-034 The bench SHALL cover: start pulsed again mid-transfer with N=3 -> ignored, byte stream unchanged, 19 bytes total.
REQ-035 The bench SHALL cover: rst_n low after the 3rd byte of an N=2 transfer -> tx_start stays 0, busy=0; a new start sends a full stream from header.
REQ-036 The bench SHALL cover: N=15, DATA_W=16 -> 451 bytes, last mem_addr=224, done exactly once.
